commit_trace_gen: RTL and testbench

Synthesizable commit-trace source inside the processor: samples the retirement-stage event signals (register write, load, store, halt) and cache request/hit strobes each cycle and packs them into fixed-width trace records. It buffers them in a small FIFO and drains them over a valid/ready port to an off-chip trace sink. On halt it appends summary records carrying the cycle, instruction, cache and drop counters. It is the producer side of the per-cycle commit log that the verification bench consumes.

---
 rtl/trace_pkg.sv | 47 ++++
 rtl/trace_fifo.sv | 47 ++++
 rtl/commit_trace_gen.sv | 131 +++++++++++++
 tb/tb_commit_trace_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace source: record layout, record kinds,
// summary indices and the controller state type.
package trace_pkg;

  localparam int REC_W      = 60;
  localparam int KIND_LSB   = 56;
  localparam int KIND_W     = 4;
  localparam int FLAGS_LSB  = 52;
  localparam int FLAGS_W    = 4;
  localparam int WREG_LSB   = 49;
  localparam int WREG_W     = 3;
  localparam int PAD_LSB    = 48;
  localparam int WDATA_LSB  = 32;
  localparam int MADDR_LSB  = 16;
  localparam int MDATA_LSB  = 0;
  localparam int DATA_W     = 16;

  localparam logic [KIND_W-1:0] KIND_COMMIT  = 4'h1;
  localparam logic [KIND_W-1:0] KIND_SUMMARY = 4'h2;

  localparam logic [2:0] SUM_CYCLES = 3'd0;
  localparam logic [2:0] SUM_INSTS  = 3'd1;
  localparam logic [2:0] SUM_DHIT   = 3'd2;
  localparam logic [2:0] SUM_IHIT   = 3'd3;
  localparam logic [2:0] SUM_DREQ   = 3'd4;
  localparam logic [2:0] SUM_IREQ   = 3'd5;
  localparam logic [2:0] SUM_DROPS  = 3'd6;
  localparam int         NUM_SUM    = 7;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SUM  = 2'd1,
    DONE = 2'd2
  } trace_state_e;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [KIND_W-1:0]  kind,
    input logic [FLAGS_W-1:0] flags,
    input logic [WREG_W-1:0]  wreg,
    input logic [DATA_W-1:0]  wdata,
    input logic [DATA_W-1:0]  maddr,
    input logic [DATA_W-1:0]  mdata
  );
    return {kind, flags, wreg, 1'b0, wdata, maddr, mdata};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with occupancy tracking; the head reads as zero while empty.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 60
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   push_ok,
  output logic                   pop_ok,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full    = (occupancy == (AW+1)'(DEPTH));
  assign empty   = (occupancy == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push on an edge that also pops
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/commit_trace_gen.sv
// Commit-trace producer: packs retirement events into records, drains them over valid/ready
// and appends counter summaries on halt. Optional pipeline backpressure: TRACE_BACKPRESSURE_EN.
module commit_trace_gen
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ev_regwr,
  input  logic [2:0]       ev_wreg,
  input  logic [15:0]      ev_wdata,
  input  logic             ev_load,
  input  logic             ev_store,
  input  logic [15:0]      ev_maddr,
  input  logic [15:0]      ev_ldata,
  input  logic [15:0]      ev_sdata,
  input  logic             ev_halt,
  input  logic             ic_req,
  input  logic             ic_hit,
  input  logic             dc_req,
  input  logic             dc_hit,
  output logic             tr_valid,
  output logic [REC_W-1:0] tr_data,
  input  logic             tr_ready,
  output logic             trace_stall,
  output logic             overflow,
  output logic             proto_err,
  output logic             trace_done
);
  localparam int OW = $clog2(DEPTH) + 1;

  trace_state_e     state, state_next;
  logic [CNT_W-1:0] cnt [NUM_SUM];
  logic [NUM_SUM-1:0] inc;
  logic [2:0]       sum_idx;
  logic [OW-1:0]    occ, occ_next;
  logic             full, empty, push, push_ok, pop_ok, drop, any_ev;
  logic [REC_W-1:0] commit_rec, summary_rec, push_rec;
  logic [31:0]      sum_val;

  assign any_ev = ev_regwr | ev_load | ev_store | ev_halt;

  // A simultaneous load and store is traced as a store
  assign commit_rec = pack_rec(KIND_COMMIT,
                               {ev_halt, ev_store, ev_load & ~ev_store, ev_regwr},
                               ev_regwr ? ev_wreg : 3'd0,
                               ev_regwr ? ev_wdata : 16'd0,
                               (ev_load | ev_store) ? ev_maddr : 16'd0,
                               ev_store ? ev_sdata : (ev_load ? ev_ldata : 16'd0));

  assign sum_val     = 32'(cnt[sum_idx]);
  assign summary_rec = pack_rec(KIND_SUMMARY, {1'b0, sum_idx}, 3'd0, 16'd0,
                                sum_val[31:16], sum_val[15:0]);

  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_rec   = commit_rec;
    case (state)
      RUN: begin
        push = any_ev;
        if (ev_halt) state_next = SUM;
      end
      SUM: begin
        push_rec = summary_rec;
        if (!full) begin
          push = 1'b1;
          if (sum_idx == SUM_DROPS) state_next = DONE;
        end
      end
      DONE: begin
      end
      default: state_next = RUN;
    endcase
  end

  assign drop = (state == RUN) && any_ev && !push_ok;
  assign inc  = {drop, ic_req, dc_req, ic_hit, dc_hit, ev_halt | ev_regwr | ev_store, 1'b1};
  assign occ_next = occ + OW'(push_ok) - OW'(pop_ok);

  trace_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (tr_ready),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .head      (tr_data),
    .full      (full),
    .empty     (empty),
    .occupancy (occ)
  );

  assign tr_valid = !empty;

`ifdef TRACE_BACKPRESSURE_EN
  // Two spare entries absorb the events already in flight when the pipeline sees the stall
  assign trace_stall = (occ >= OW'(DEPTH - 2));
`else
  assign trace_stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      sum_idx    <= '0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
      trace_done <= 1'b0;
      for (int i = 0; i < NUM_SUM; i++) cnt[i] <= '0;
    end else begin
      state      <= state_next;
      trace_done <= (state_next == DONE) && (occ_next == '0);
      if (state == RUN) begin
        overflow  <= overflow | drop;
        proto_err <= proto_err | (ev_load & ev_store);
        for (int i = 0; i < NUM_SUM; i++) begin
          if (inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      if ((state == SUM) && push_ok) sum_idx <= sum_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_commit_trace_gen.sv
// Self-checking bench for commit_trace_gen: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the trace source.
module tb_commit_trace_gen;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ev_regwr, ev_load, ev_store, ev_halt;
  logic [2:0]  ev_wreg;
  logic [15:0] ev_wdata, ev_maddr, ev_ldata, ev_sdata;
  logic        ic_req, ic_hit, dc_req, dc_hit;
  logic        tr_valid, tr_ready, trace_stall, overflow, proto_err, trace_done;
  logic [59:0] tr_data;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state
  logic [59:0]     q[$];
  int              m_mode;
  int              m_idx;
  longint unsigned m_cnt[7];
  bit              m_ovf, m_perr;

  commit_trace_gen #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ev_regwr(ev_regwr), .ev_wreg(ev_wreg), .ev_wdata(ev_wdata),
    .ev_load(ev_load), .ev_store(ev_store), .ev_maddr(ev_maddr),
    .ev_ldata(ev_ldata), .ev_sdata(ev_sdata), .ev_halt(ev_halt),
    .ic_req(ic_req), .ic_hit(ic_hit), .dc_req(dc_req), .dc_hit(dc_hit),
    .tr_valid(tr_valid), .tr_data(tr_data), .tr_ready(tr_ready),
    .trace_stall(trace_stall), .overflow(overflow), .proto_err(proto_err),
    .trace_done(trace_done)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ev_regwr = 0; ev_load = 0; ev_store = 0; ev_halt = 0;
    ev_wreg = 0; ev_wdata = 0; ev_maddr = 0; ev_ldata = 0; ev_sdata = 0;
    ic_req = 0; ic_hit = 0; dc_req = 0; dc_hit = 0;
  endtask

  // Advance one clock; the model applies the same edge, then outputs settle for sampling.
  task automatic tick();
    bit          pop, room, any, push;
    bit [6:0]    inc;
    logic [59:0] rec;
    logic [31:0] v;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_mode = 0; m_idx = 0; m_ovf = 0; m_perr = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      pop  = (q.size() > 0) && tr_ready;
      room = (q.size() < DEPTH) || pop;
      push = 0;
      rec  = '0;
      if (m_mode == 0) begin
        any = ev_regwr | ev_load | ev_store | ev_halt;
        inc = {any && !room, ic_req, dc_req, ic_hit, dc_hit, ev_halt | ev_regwr | ev_store, 1'b1};
        for (int i = 0; i < 7; i++)
          if (inc[i] && m_cnt[i] < 64'hFFFF_FFFF) m_cnt[i]++;
        if (ev_load && ev_store) m_perr = 1;
        if (any && !room) m_ovf = 1;
        if (any && room) begin
          push = 1;
          rec = {4'h1, ev_halt, ev_store, ev_load && !ev_store, ev_regwr,
                 ev_regwr ? ev_wreg : 3'd0, 1'b0,
                 ev_regwr ? ev_wdata : 16'd0,
                 (ev_load || ev_store) ? ev_maddr : 16'd0,
                 ev_store ? ev_sdata : (ev_load ? ev_ldata : 16'd0)};
        end
        if (ev_halt) begin m_mode = 1; m_idx = 0; end
      end else if (m_mode == 1) begin
        if (q.size() < DEPTH) begin
          v    = m_cnt[m_idx][31:0];
          rec  = {4'h2, 4'(m_idx), 4'h0, 16'h0, v[31:16], v[15:0]};
          push = 1;
          m_idx++;
          if (m_idx == 7) m_mode = 2;
        end
      end
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(rec);
    end
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    tr_ready = 0;
    apply_reset();
    n_vec++; if (tr_valid !== 1'b0)    begin n_miss++; $display("[TB] FAIL reset_tr_valid: got %b want 0", tr_valid); end
    n_vec++; if (tr_data !== 60'h0)    begin n_miss++; $display("[TB] FAIL reset_tr_data: got %h want 0", tr_data); end
    n_vec++; if (trace_stall !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_stall: got %b want 0", trace_stall); end
    n_vec++; if (overflow !== 1'b0)    begin n_miss++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    n_vec++; if (proto_err !== 1'b0)   begin n_miss++; $display("[TB] FAIL reset_proto_err: got %b want 0", proto_err); end
    n_vec++; if (trace_done !== 1'b0)  begin n_miss++; $display("[TB] FAIL reset_done: got %b want 0", trace_done); end
  endtask

  task automatic test_single_commit();
    tr_ready = 1;
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_vec++; if (tr_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL idle_valid cycle %0d: got %b want 0", c, tr_valid); end
    end
    ev_regwr = 1; ev_wreg = 3'd3; ev_wdata = 16'h1234;
    tick();
    idle_inputs();
    n_vec++; if (tr_valid !== 1'b1) begin n_miss++; $display("[TB] FAIL commit_valid: got %b want 1", tr_valid); end
    n_vec++; if (tr_data !== 60'h116_1234_0000_0000) begin n_miss++; $display("[TB] FAIL commit_rec: got %h want %h", tr_data, 60'h116_1234_0000_0000); end
    tick();
    n_vec++; if (tr_valid !== 1'b0) begin n_miss++; $display("[TB] FAIL commit_after_valid: got %b want 0", tr_valid); end
  endtask

  task automatic test_overflow();
    bit got_last;
    tr_ready = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      ev_store = 1; ev_maddr = 16'(i); ev_sdata = 16'($urandom);
      tick();
    end
    idle_inputs();
    n_vec++; if (overflow !== 1'b1) begin n_miss++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); end
    n_vec++; if (tr_valid !== 1'b1 || tr_data !== q[0]) begin n_miss++; $display("[TB] FAIL ovf_head: got %b/%h want 1/%h", tr_valid, tr_data, q[0]); end
    // halt on an edge that also pops, so the halt commit fits
    ev_halt = 1; tr_ready = 1;
    tick();
    ev_halt = 0;
    got_last = 0;
    for (int c = 0; c < 60 && trace_done !== 1'b1; c++) begin
      if (q.size() > 0) begin
        n_vec++; if (tr_valid !== 1'b1 || tr_data !== q[0]) begin n_miss++; $display("[TB] FAIL ovf_drain: got %b/%h want 1/%h", tr_valid, tr_data, q[0]); end
      end
      if (tr_valid === 1'b1 && tr_data[59:56] === 4'h2 && tr_data[55:52] === 4'h6) begin
        got_last = 1;
        n_vec++; if (tr_data[31:0] !== 32'h0000_0002) begin n_miss++; $display("[TB] FAIL ovf_drops_summary: got %h want 00000002", tr_data[31:0]); end
      end
      tick();
    end
    n_vec++; if (got_last !== 1'b1)  begin n_miss++; $display("[TB] FAIL ovf_summary_seen: got %b want 1", got_last); end
    n_vec++; if (trace_done !== 1'b1) begin n_miss++; $display("[TB] FAIL ovf_done: got %b want 1", trace_done); end
    n_vec++; if (overflow !== 1'b1)  begin n_miss++; $display("[TB] FAIL ovf_still_set: got %b want 1", overflow); end
  endtask

`ifdef TRACE_BACKPRESSURE_EN
  task automatic test_backpressure();
    int issued, rise_at;
    tr_ready = 0;
    apply_reset();
    issued = 0; rise_at = -1;
    for (int i = 0; i < 10; i++) begin
      ev_store = !trace_stall; ev_maddr = 16'(i); ev_sdata = 16'($urandom);
      if (!trace_stall) issued++;
      tick();
      n_vec++; if (trace_stall !== (q.size() >= DEPTH - 2)) begin n_miss++; $display("[TB] FAIL bp_stall occ %0d: got %b", q.size(), trace_stall); end
      if (trace_stall === 1'b1 && rise_at < 0) rise_at = issued;
    end
    idle_inputs();
    n_vec++; if (rise_at != 6)       begin n_miss++; $display("[TB] FAIL bp_rise: got %0d want 6", rise_at); end
    n_vec++; if (overflow !== 1'b0)  begin n_miss++; $display("[TB] FAIL bp_overflow: got %b want 0", overflow); end
  endtask
`endif

  task automatic test_proto_err();
    tr_ready = 1;
    apply_reset();
    n_vec++; if (proto_err !== 1'b0) begin n_miss++; $display("[TB] FAIL perr_pre: got %b want 0", proto_err); end
    ev_load = 1; ev_store = 1; ev_maddr = 16'h0040; ev_sdata = 16'hBEEF; ev_ldata = 16'h5555;
    tick();
    idle_inputs();
    n_vec++; if (tr_data !== 60'h140_0000_0040_BEEF) begin n_miss++; $display("[TB] FAIL perr_rec: got %h want %h", tr_data, 60'h140_0000_0040_BEEF); end
    n_vec++; if (proto_err !== 1'b1) begin n_miss++; $display("[TB] FAIL perr_set: got %b want 1", proto_err); end
    tick();
    n_vec++; if (proto_err !== 1'b1) begin n_miss++; $display("[TB] FAIL perr_sticky: got %b want 1", proto_err); end
  endtask

  task automatic test_summary_counts();
    logic [31:0] exp_sum[7];
    int seen, idx;
    exp_sum[0] = 21; exp_sum[1] = 21; exp_sum[2] = 0; exp_sum[3] = 15;
    exp_sum[4] = 0;  exp_sum[5] = 20; exp_sum[6] = 0;
    tr_ready = 1;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      ev_regwr = 1; ev_wreg = 3'($urandom); ev_wdata = 16'($urandom);
      ic_req = 1; ic_hit = (c < 15);
      tick();
    end
    idle_inputs();
    ev_halt = 1;
    tick();
    ev_halt = 0;
    seen = 0;
    for (int c = 0; c < 40 && trace_done !== 1'b1; c++) begin
      if (tr_valid === 1'b1 && tr_data[59:56] === 4'h2) begin
        idx = int'(tr_data[55:52]);
        if (idx < 7) begin
          seen++;
          n_vec++; if (tr_data[31:0] !== exp_sum[idx] || tr_data[51:32] !== 20'h0) begin n_miss++; $display("[TB] FAIL summary_%0d: got %h want %h", idx, tr_data[51:0], {20'h0, exp_sum[idx]}); end
        end
      end
      tick();
    end
    n_vec++; if (seen != 7) begin n_miss++; $display("[TB] FAIL summary_seen: got %0d want 7", seen); end
  endtask

  task automatic test_halt_timing();
    int done_at;
    tr_ready = 1;
    apply_reset();
    ev_halt = 1;
    tick();
    ev_halt = 0;
    n_vec++; if (tr_valid !== 1'b1 || tr_data !== 60'h180_0000_0000_0000) begin n_miss++; $display("[TB] FAIL halt_commit: got %b/%h want 1/%h", tr_valid, tr_data, 60'h180_0000_0000_0000); end
    done_at = 0;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (k == 2) begin
        n_vec++; if (tr_data !== 60'h200_0000_0000_0001) begin n_miss++; $display("[TB] FAIL halt_sum0: got %h want %h", tr_data, 60'h200_0000_0000_0001); end
      end
      if (trace_done === 1'b1 && done_at == 0) done_at = k;
    end
    n_vec++; if (done_at != 9) begin n_miss++; $display("[TB] FAIL halt_done_cycle: got N+%0d want N+9", done_at); end
    ev_regwr = 1; ev_store = 1; ev_halt = 1;
    tick(); tick();
    idle_inputs();
    n_vec++; if (tr_valid !== 1'b0)   begin n_miss++; $display("[TB] FAIL done_ignore: got %b want 0", tr_valid); end
    n_vec++; if (trace_done !== 1'b1) begin n_miss++; $display("[TB] FAIL done_hold: got %b want 1", trace_done); end
  endtask

  task automatic test_reset_in_sum();
    tr_ready = 0;
    apply_reset();
    ev_halt = 1;
    tick();
    ev_halt = 0;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    n_vec++; if (tr_valid !== 1'b0)   begin n_miss++; $display("[TB] FAIL rsum_valid: got %b want 0", tr_valid); end
    n_vec++; if (trace_done !== 1'b0) begin n_miss++; $display("[TB] FAIL rsum_done: got %b want 0", trace_done); end
    tr_ready = 1; ev_halt = 1;
    tick();
    ev_halt = 0;
    n_vec++; if (tr_data !== 60'h180_0000_0000_0000) begin n_miss++; $display("[TB] FAIL rsum_commit: got %h want %h", tr_data, 60'h180_0000_0000_0000); end
    tick();
    n_vec++; if (tr_data !== 60'h200_0000_0000_0001) begin n_miss++; $display("[TB] FAIL rsum_cycles: got %h want %h", tr_data, 60'h200_0000_0000_0001); end
    tick();
    n_vec++; if (tr_data !== 60'h210_0000_0000_0001) begin n_miss++; $display("[TB] FAIL rsum_insts: got %h want %h", tr_data, 60'h210_0000_0000_0001); end
  endtask

  task automatic test_random();
    bit exp_stall;
    for (int seg = 0; seg < 4; seg++) begin
      apply_reset();
      for (int c = 0; c < 150; c++) begin
        ev_regwr = ($urandom_range(0, 2) == 0); ev_wreg = 3'($urandom); ev_wdata = 16'($urandom);
        ev_load  = ($urandom_range(0, 2) == 0); ev_store = ($urandom_range(0, 2) == 0);
        ev_maddr = 16'($urandom); ev_ldata = 16'($urandom); ev_sdata = 16'($urandom);
        ev_halt  = ($urandom_range(0, 59) == 0);
        ic_req = 1'($urandom); ic_hit = 1'($urandom); dc_req = 1'($urandom); dc_hit = 1'($urandom);
        tr_ready = 1'($urandom);
        tick();
`ifdef TRACE_BACKPRESSURE_EN
        exp_stall = (q.size() >= DEPTH - 2);
`else
        exp_stall = 0;
`endif
        n_vec++; if (tr_valid !== (q.size() > 0)) begin n_miss++; $display("[TB] FAIL rnd_valid s%0d c%0d: got %b want %b", seg, c, tr_valid, q.size() > 0); end
        if (q.size() > 0) begin
          n_vec++; if (tr_data !== q[0]) begin n_miss++; $display("[TB] FAIL rnd_data s%0d c%0d: got %h want %h", seg, c, tr_data, q[0]); end
        end
        n_vec++; if (overflow !== m_ovf)    begin n_miss++; $display("[TB] FAIL rnd_overflow s%0d c%0d: got %b want %b", seg, c, overflow, m_ovf); end
        n_vec++; if (proto_err !== m_perr)  begin n_miss++; $display("[TB] FAIL rnd_proto_err s%0d c%0d: got %b want %b", seg, c, proto_err, m_perr); end
        n_vec++; if (trace_done !== (m_mode == 2 && q.size() == 0)) begin n_miss++; $display("[TB] FAIL rnd_done s%0d c%0d: got %b", seg, c, trace_done); end
        n_vec++; if (trace_stall !== exp_stall) begin n_miss++; $display("[TB] FAIL rnd_stall s%0d c%0d: got %b want %b", seg, c, trace_stall, exp_stall); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    tr_ready = 0;
    idle_inputs();
    test_reset();
    test_single_commit();
    test_overflow();
`ifdef TRACE_BACKPRESSURE_EN
    test_backpressure();
`endif
    test_proto_err();
    test_summary_counts();
    test_halt_timing();
    test_reset_in_sum();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
